led_chaser_seq: RTL and testbench
=================================

// Module: led_chaser_seq
// PURPOSE
//  Running-light sequencer; sits directly upstream of the one-hot LED decoder.
//  Generates the 3-bit LED index (switch) and 3-bit decoder enable code each step.
//  Decoder lights exactly one LED when enable==3'd4; any other code blanks all LEDs.
//  Step rate set by an internal prescaler; supports wrap and bounce patterns.
// PARAMETERS
//  DIV_W  4  width of prescaler counter
//  DIV    3  tick period minus one; step every DIV+1 clk cycles (0 = every cycle)
// PORTS
//  clk       in   1      system clock, all logic on posedge
//  rst_n     in   1      asynchronous reset, active-low
//  run       in   1      1 = sequence advancing, 0 = hold (IDLE)
//  dir       in   1      0 = up (index+1), 1 = down (index-1)
//  mode      in   1      0 = wrap 7->0 / 0->7, 1 = bounce at 0 and 7
//  load      in   1      1-cycle strobe: force index to load_pos
//  load_pos  in   3      index value for load
//  switch    out  3      LED index to decoder (registered)
//  enable    out  3      decoder enable code (registered); 3'd4 = lit, 3'd0 = blank
//  tick      out  1      1-cycle pulse on each prescaler terminal count
//  wrap      out  1      1-cycle pulse, same cycle index turns at an end (wrap or bounce)
// BEHAVIOUR
//  - Clock clk, reset rst_n: one clock domain; reset asynchronous, active-low.
//  - Reset (rst_n=0): state=IDLE, pos=0, div_cnt=0.
//    Outputs: switch=0, enable=0, tick=0, wrap=0. Outputs stay there while rst_n low.
//  - Prescaler: div_cnt counts 0..DIV and then returns to 0, free-running in all states.
//    tick=1 for the cycle after div_cnt==DIV (registered). With DIV=0, tick is constantly 1.
//  - States: IDLE, RUN_UP, RUN_DOWN.
//    IDLE & run=1 -> RUN_UP if dir=0, else RUN_DOWN.
//    RUN_* & run=0 -> IDLE; pos held.
//    mode=0 & running: state follows dir every cycle.
//    mode=1 & running: dir ignored; direction changes only at a bounce.
//  - Step: on a cycle where state is RUN_* and the prescaler hits terminal count:
//    RUN_UP: pos+1. At pos=7: mode0 -> 0; mode1 -> 6 and state to RUN_DOWN. wrap=1.
//    RUN_DOWN: pos-1. At pos=0: mode0 -> 7; mode1 -> 1 and state to RUN_UP. wrap=1.
//    All pos arithmetic is 3-bit; no other values are reachable.
//  - Latency: switch/enable reflect pos/state one cycle after update (registered).
//    The first step occurs at the first terminal count after entering RUN_*.
//  - load=1 has top priority over step, run and dir:
//    pos<=load_pos, div_cnt<=0, no step that cycle, state unchanged.
//  - enable=3'd4 in RUN_*. In IDLE: 3'd0 (blank), unless the macro below is defined.
//  - Reset mid-run aborts immediately to reset values. No partial step is retained.
// CONFIGURATION
//  Macro LED_CHASER_BLINK_EN:
//  - Defined: in IDLE, enable toggles 3'd4 <-> 3'd0 on every tick, so the held LED blinks.
//    The toggle phase resets to 3'd0 on entering IDLE. RUN_* behaviour unchanged.
//  - Undefined: enable=3'd0 in IDLE, so all LEDs are off while held.
// TESTING
//  1 Reset: rst_n=0 mid-run
//    -> switch=0, enable=0, tick=0, wrap=0 immediately, with no clock edge.
//  2 Wrap up: DIV=3, mode=0, dir=0, run=1 from reset
//    -> switch steps 0,1,..7,0 every 4 clks; wrap=1 on the 7->0 step; enable=4 throughout.
//  3 Bounce: mode=1, load_pos=6, run=1
//    -> 6,7,6,5,...,0,1; wrap pulses at 7 and at 0; toggling dir has no effect.
//  4 Load priority: load=1, load_pos=5 on a tick cycle while running up from 2
//    -> switch=5 next, no step that cycle.
//    The next step (to 6) comes DIV+1 clks after load.
//  5 Hold: run=0 at switch=3
//    -> switch stays 3; enable=0 (macro off), or toggles 4/0 per tick (macro on).
//    run=1 resumes from 3.
//  6 DIV=0, mode=0, dir=1
//    -> switch decrements every clk: 0,7,6,...; wrap on the 0->7 step.

Source files
------------

// File: rtl/led_chaser_seq.sv
// ============================================================================
// Module   : led_chaser_seq
// Purpose  : Running-light sequencer feeding a one-hot LED decoder (index +
//            enable code). Optional idle blink via macro LED_CHASER_BLINK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module led_chaser_seq #(
    parameter int          DIV_W = 4,
    parameter int unsigned DIV   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       dir,
    input  logic       mode,
    input  logic       load,
    input  logic [2:0] load_pos,
    output logic [2:0] switch,
    output logic [2:0] enable,
    output logic       tick,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] C_DIV    = DIV[DIV_W-1:0];
    localparam logic [2:0]       C_EN_LIT = 3'd4;
    localparam logic [2:0]       C_EN_OFF = 3'd0;

    state_t             state_q, state_d;
    logic [2:0]         pos_q, pos_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               tick_q, tick_d;
    logic               wrap_q, wrap_d;
    logic [2:0]         enable_q, enable_d;
    logic               w_term;
    logic               w_go_down;
    logic               w_idle_hold;
`ifdef LED_CHASER_BLINK_EN
    logic               blink_q, blink_d;
`endif

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        wrap_d      = 1'b0;
        w_go_down   = 1'b0;
        w_term      = (div_cnt_q == C_DIV);
        div_cnt_d   = w_term ? '0 : div_cnt_q + 1'b1;
        tick_d      = w_term;

        if (load) begin
            // Load restarts the prescaler so the next step is a full period away.
            pos_d     = load_pos;
            div_cnt_d = '0;
            tick_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d = dir ? RUN_DOWN : RUN_UP;
                    end
                end
                RUN_UP, RUN_DOWN: begin
                    if (!run) begin
                        state_d = IDLE;
                    end else begin
                        w_go_down = mode ? (state_q == RUN_DOWN) : dir;
                        state_d   = w_go_down ? RUN_DOWN : RUN_UP;
                        if (w_term) begin
                            wrap_d = w_go_down ? (pos_q == 3'd0) : (pos_q == 3'd7);
                            pos_d  = w_go_down ? pos_q - 3'd1 : pos_q + 3'd1;
                            // Bounce reflects off the end instead of wrapping around.
                            if (wrap_d && mode) begin
                                pos_d   = w_go_down ? 3'd1 : 3'd6;
                                state_d = w_go_down ? RUN_UP : RUN_DOWN;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        w_idle_hold = (state_q == IDLE) && (state_d == IDLE);
`ifdef LED_CHASER_BLINK_EN
        blink_d  = w_idle_hold ? (blink_q ^ tick_d) : 1'b0;
        enable_d = ((state_d != IDLE) || blink_d) ? C_EN_LIT : C_EN_OFF;
`else
        enable_d = (state_d != IDLE) ? C_EN_LIT : C_EN_OFF;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pos_q     <= 3'd0;
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            enable_q  <= C_EN_OFF;
`ifdef LED_CHASER_BLINK_EN
            blink_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            enable_q  <= enable_d;
`ifdef LED_CHASER_BLINK_EN
            blink_q   <= blink_d;
`endif
        end
    end

    assign switch = pos_q;
    assign enable = enable_q;
    assign tick   = tick_q;
    assign wrap   = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_led_chaser_seq.sv
// ============================================================================
// Module   : tb_led_chaser_seq
// Purpose  : Scoreboard bench for led_chaser_seq, two instances (DIV=3, DIV=0).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_led_chaser_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, dir, mode, load;
    logic [2:0] load_pos;
    logic [2:0] sw_a, en_a, sw_b, en_b;
    logic       tick_a, wrap_a, tick_b, wrap_b;

    always #5 clk = ~clk;

    led_chaser_seq #(.DIV_W(4), .DIV(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .run(run), .dir(dir), .mode(mode),
        .load(load), .load_pos(load_pos),
        .switch(sw_a), .enable(en_a), .tick(tick_a), .wrap(wrap_a)
    );

    led_chaser_seq #(.DIV_W(4), .DIV(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .run(run), .dir(dir), .mode(mode),
        .load(load), .load_pos(load_pos),
        .switch(sw_b), .enable(en_b), .tick(tick_b), .wrap(wrap_b)
    );

    typedef struct {
        bit running;
        bit down;
        bit blink;
        int pos;
        int cnt;
        bit tick;
        bit wrap;
    } mstate_t;

    mstate_t      ma, mb;
    logic [15:0]  exp_q[$];
    int           n_vec = 0;
    int           n_bad = 0;

    function automatic mstate_t model_reset();
        mstate_t s;
        s.running = 0; s.down = 0; s.blink = 0;
        s.pos = 0; s.cnt = 0; s.tick = 0; s.wrap = 0;
        return s;
    endfunction

    // One clock of the running-light rules for a prescaler period of div+1.
    function automatic mstate_t model_step(mstate_t s, int div, bit r, bit d,
                                           bit m, bit ld, int lpos);
        mstate_t n = s;
        bit term = (s.cnt == div);
        int nxt;
        n.tick = 0;
        n.wrap = 0;
        if (ld) begin
            n.pos = lpos;
            n.cnt = 0;
            return n;
        end
        n.cnt  = term ? 0 : s.cnt + 1;
        n.tick = term;
        if (!s.running) begin
            if (r) begin
                n.running = 1;
                n.down    = d;
                n.blink   = 0;
            end else if (term) begin
                n.blink = !s.blink;
            end
        end else if (!r) begin
            n.running = 0;
            n.blink   = 0;
        end else begin
            if (!m) n.down = d;
            if (term) begin
                nxt = n.down ? s.pos - 1 : s.pos + 1;
                if (nxt < 0 || nxt > 7) begin
                    n.wrap = 1;
                    if (m) begin
                        n.pos  = n.down ? 1 : 6;
                        n.down = !n.down;
                    end else begin
                        n.pos = (nxt + 8) % 8;
                    end
                end else begin
                    n.pos = nxt;
                end
            end
        end
`ifndef LED_CHASER_BLINK_EN
        n.blink = 0;
`endif
        return n;
    endfunction

    function automatic logic [7:0] pack(mstate_t s);
        logic [2:0] en;
        en = (s.running || s.blink) ? 3'd4 : 3'd0;
        return {3'(s.pos), en, s.tick, s.wrap};
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got sw=%0d en=%0d tick=%b wrap=%b, expected sw=%0d en=%0d tick=%b wrap=%b",
                     name, $time, act[7:5], act[4:2], act[1], act[0],
                     exp[7:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // Monitor: every DUT output cycle with a pending expectation is scored.
    always @(posedge clk) begin
        logic [15:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("div3", {sw_a, en_a, tick_a, wrap_a}, e[15:8]);
            check("div0", {sw_b, en_b, tick_b, wrap_b}, e[7:0]);
        end
    end

    task automatic drive(bit r, bit d, bit m, bit ld, int lpos);
        @(negedge clk);
        rst_n    = 1'b1;
        run      = r;
        dir      = d;
        mode     = m;
        load     = ld;
        load_pos = 3'(lpos);
        ma = model_step(ma, 3, r, d, m, ld, lpos);
        mb = model_step(mb, 0, r, d, m, ld, lpos);
        exp_q.push_back({pack(ma), pack(mb)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_a", {sw_a, en_a, tick_a, wrap_a}, 8'h00);
        check("rst_async_b", {sw_b, en_b, tick_b, wrap_b}, 8'h00);
        @(negedge clk);
        check("rst_hold_a", {sw_a, en_a, tick_a, wrap_a}, 8'h00);
        @(negedge clk);
        ma = model_reset();
        mb = model_reset();
    endtask

    initial begin
        bit r_r, d_r, m_r, l_r;
        rst_n = 1'b0; run = 0; dir = 0; mode = 0; load = 0; load_pos = 3'd0;
        ma = model_reset();
        mb = model_reset();
        repeat (2) @(negedge clk);
        check("reset_a", {sw_a, en_a, tick_a, wrap_a}, 8'h00);
        check("reset_b", {sw_b, en_b, tick_b, wrap_b}, 8'h00);

        // Wrap up with DIV=3 (and DIV=0 alongside)
        repeat (40) drive(1, 0, 0, 0, 0);
        // Bounce from 6, dir toggled randomly
        drive(1, 0, 1, 1, 6);
        repeat (70) drive(1, 1'($urandom), 1, 0, 0);
        // Load restarts the prescaler; second load lands on a terminal count
        drive(1, 0, 0, 1, 2);
        repeat (3) drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 5);
        repeat (8) drive(1, 0, 0, 0, 0);
        // Hold and resume
        drive(1, 0, 0, 1, 3);
        repeat (20) drive(0, 0, 0, 0, 0);
        repeat (10) drive(1, 0, 0, 0, 0);
        // Wrap down
        repeat (20) drive(1, 1, 0, 0, 0);
        do_reset();
        repeat (20) drive(1, 1, 0, 0, 0);

        r_r = 1; d_r = 0; m_r = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) r_r = !r_r;
            if ($urandom_range(0, 19) == 0) d_r = !d_r;
            if ($urandom_range(0, 49) == 0) m_r = !m_r;
            l_r = ($urandom_range(0, 24) == 0);
            drive(r_r, d_r, m_r, l_r, int'($urandom_range(0, 7)));
            if (i == 700) do_reset();
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
